// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state codes, widths and LED patterns for the alarm trigger
package alarm_pkg;
   localparam int STATE_W    = 3;
   localparam int BCD_TIME_W = 24;

   localparam logic [STATE_W-1:0] IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ARMED   = 3'd1;
   localparam logic [STATE_W-1:0] RINGING = 3'd2;
   localparam logic [STATE_W-1:0] SNOOZE  = 3'd3;
   localparam logic [STATE_W-1:0] DONE    = 3'd4;

   localparam logic [7:0] LED_OFF     = 8'h00;
   localparam logic [7:0] LED_RING    = 8'hFF;
   localparam logic [7:0] LED_BLINK_A = 8'hAA;
   localparam logic [7:0] LED_BLINK_B = 8'h55;
   localparam logic [7:0] LED_SNOOZE  = 8'h01;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/btn_rise.sv
// rtl/btn_rise.sv - registered rising-edge detector for a debounced button level
module btn_rise (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);
   logic btn_q;

   always_ff @(posedge clk) begin
      if (rst) btn_q <= 1'b0;
      else     btn_q <= btn;
   end

   assign rise = btn & ~btn_q;
endmodule

// File: rtl/alarm_trigger.sv
// rtl/alarm_trigger.sv - alarm compare plus ring/snooze/dismiss FSM with second timers
// Optional blinking LED patterns under ALARM_TRIGGER_BLINK_EN.
module alarm_trigger
   import alarm_pkg::*;
#(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_SECONDS = 300,
   parameter int MAX_SNOOZE     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  enable,
   input  logic [BCD_TIME_W-1:0] now_bcd,
   input  logic [BCD_TIME_W-1:0] alarm_bcd,
   input  logic                  btn_dismiss,
   input  logic                  btn_snooze,
   output logic                  ringing,
   output logic [STATE_W-1:0]    state,
   output logic [3:0]            snoozes,
   output logic [7:0]            led
);
   localparam int CNT_W = $clog2(max_int(RING_SECONDS, SNOOZE_SECONDS) + 1);
   localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECONDS - 1);
   localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECONDS - 1);
   localparam logic [3:0]       SNOOZE_MAX  = 4'(MAX_SNOOZE);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   ring_cnt_q, ring_cnt_d;
   logic [CNT_W-1:0]   snooze_cnt_q, snooze_cnt_d;
   logic [3:0]         snoozes_q, snoozes_d;
   logic               match, dismiss_rise, snooze_rise;

   // Invalid BCD digits need no special handling: they never equal a valid time.
   assign match = (now_bcd == alarm_bcd);

   btn_rise u_dismiss (.clk(clk), .rst(rst), .btn(btn_dismiss), .rise(dismiss_rise));
   btn_rise u_snooze  (.clk(clk), .rst(rst), .btn(btn_snooze),  .rise(snooze_rise));

`ifdef ALARM_TRIGGER_BLINK_EN
   logic blink_q, blink_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ring_cnt_q   <= '0;
         snooze_cnt_q <= '0;
         snoozes_q    <= '0;
`ifdef ALARM_TRIGGER_BLINK_EN
         blink_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         ring_cnt_q   <= ring_cnt_d;
         snooze_cnt_q <= snooze_cnt_d;
         snoozes_q    <= snoozes_d;
`ifdef ALARM_TRIGGER_BLINK_EN
         blink_q      <= blink_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      ring_cnt_d   = ring_cnt_q;
      snooze_cnt_d = snooze_cnt_q;
      snoozes_d    = snoozes_q;
      if (!enable) begin
         state_d      = IDLE;
         ring_cnt_d   = '0;
         snooze_cnt_d = '0;
         snoozes_d    = '0;
      end else begin
         case (state_q)
            IDLE: state_d = ARMED;
            ARMED: begin
               if (match) begin
                  state_d    = RINGING;
                  ring_cnt_d = '0;
                  snoozes_d  = '0;
               end
            end
            RINGING: begin
               // Dismiss outranks snooze and timeout; a snooze beyond the limit falls through to the timer.
               if (dismiss_rise) begin
                  state_d = DONE;
               end else if (snooze_rise && (snoozes_q < SNOOZE_MAX)) begin
                  state_d      = SNOOZE;
                  snooze_cnt_d = '0;
                  snoozes_d    = snoozes_q + 4'd1;
               end else if (tick) begin
                  if (ring_cnt_q == RING_LAST) state_d = DONE;
                  else                         ring_cnt_d = ring_cnt_q + CNT_W'(1);
               end
            end
            SNOOZE: begin
               if (dismiss_rise) begin
                  state_d = DONE;
               end else if (tick) begin
                  if (snooze_cnt_q == SNOOZE_LAST) begin
                     state_d    = RINGING;
                     ring_cnt_d = '0;
                  end else begin
                     snooze_cnt_d = snooze_cnt_q + CNT_W'(1);
                  end
               end
            end
            // Wait out the matching second so the same alarm cannot re-trigger.
            DONE: if (!match) state_d = ARMED;
            default: state_d = IDLE;
         endcase
      end
`ifdef ALARM_TRIGGER_BLINK_EN
      blink_d = blink_q;
      if (state_d == RINGING && state_q != RINGING)      blink_d = 1'b0;
      else if (state_d == RINGING && tick)               blink_d = ~blink_q;
`endif
   end

   always_comb begin
      ringing = (state_q == RINGING);
`ifdef ALARM_TRIGGER_BLINK_EN
      case (state_q)
         RINGING: led = blink_q ? LED_BLINK_B : LED_BLINK_A;
         SNOOZE:  led = LED_SNOOZE;
         default: led = LED_OFF;
      endcase
`else
      led = (state_q == RINGING) ? LED_RING : LED_OFF;
`endif
   end

   assign state   = state_q;
   assign snoozes = snoozes_q;
endmodule
